// File: rtl/r5p_rst_pkg.sv
// ---------------------------------------------------------------------------
// r5p_rst_pkg
// Shared types and default constants for the R5P board reset conditioner.
//   rst_st_t      : reset FSM state encoding
//   *_DEF         : default parameter values for a 27 MHz board clock
//   rst_of_state  : SoC reset level implied by a reset FSM state
// ---------------------------------------------------------------------------
package r5p_rst_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PRESSED = 2'd2
  } rst_st_t;

  localparam int unsigned SYNC_FF_DEF = 32'd2;
  localparam int unsigned DEB_CNT_DEF = 32'd270000;  // 10 ms at 27 MHz
  localparam int unsigned RST_LEN_DEF = 32'd16;
  localparam logic        BTN_POL_DEF = 1'b0;        // board buttons are active-low

  // The SoC is held in reset in every state except ST_RUN.
  function automatic logic rst_of_state(input rst_st_t st);
    return (st != ST_RUN);
  endfunction

endpackage

// File: rtl/r5p_debounce.sv
// ---------------------------------------------------------------------------
// r5p_debounce
// Synchronizes a raw asynchronous push-button, normalizes its polarity
// (1 = pressed) and accepts a level change only after DEB_CNT consecutive
// cycles of the new level.
// Ports:
//   clk            in  system clock
//   rst_n          in  asynchronous active-low reset
//   btn_i          in  raw button pin
//   btn_deb_o      out debounced state, 1 = pressed
//   btn_press_o    out 1-cycle pulse when btn_deb_o goes 0->1
//   btn_release_o  out 1-cycle pulse when btn_deb_o goes 1->0
// ---------------------------------------------------------------------------
module r5p_debounce
  import r5p_rst_pkg::*;
#(
  parameter int unsigned SYNC_FF = SYNC_FF_DEF,
  parameter int unsigned DEB_CNT = DEB_CNT_DEF,
  parameter logic        BTN_POL = BTN_POL_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic btn_deb_o,
  output logic btn_press_o,
  output logic btn_release_o
);

  localparam int unsigned    CW      = $clog2(DEB_CNT + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEB_CNT - 1);

  logic [SYNC_FF-1:0] sync_q;
  logic               btn_s;
  logic [CW-1:0]      cnt_q,     cnt_d;
  logic               deb_q,     deb_d;
  logic               press_q,   press_d;
  logic               release_q, release_d;

  // Synchronizer chain; resets to the released pin level so no press is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_FF{~BTN_POL}};
    end else begin
      sync_q <= {sync_q[SYNC_FF-2:0], btn_i};
    end
  end

  assign btn_s = (sync_q[SYNC_FF-1] == BTN_POL);

  // Debounce next-state: count disagreeing cycles, any agreeing cycle restarts.
  always_comb begin
    cnt_d     = cnt_q;
    deb_d     = deb_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (btn_s != deb_q) begin
      if (cnt_q == CNT_MAX) begin
        deb_d     = btn_s;
        cnt_d     = '0;
        press_d   = btn_s;
        release_d = ~btn_s;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Debounce state and edge pulses, all updated on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      deb_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      deb_q     <= deb_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_deb_o     = deb_q;
  assign btn_press_o   = press_q;
  assign btn_release_o = release_q;

endmodule

// File: rtl/r5p_reset_button_ctl.sv
// ---------------------------------------------------------------------------
// r5p_reset_button_ctl
// Board-level reset conditioner for the R5P SoC. Debounces the reset button
// and produces a registered, stretched, synchronously released active-high
// SoC reset.
// Build option: define R5P_RST_LOCK_EN to add the pll_lock input; a low
// synchronized lock holds the SoC in reset and restarts the stretch.
// Ports:
//   clk          in  system clock
//   rst_n        in  asynchronous active-low power-on reset
//   btn_i        in  raw reset button pin
//   pll_lock     in  PLL lock, asynchronous (R5P_RST_LOCK_EN only)
//   rst          out active-high SoC reset, single flop
//   btn_deb      out debounced button, 1 = pressed
//   btn_press    out 1-cycle pulse on debounced press
//   btn_release  out 1-cycle pulse on debounced release
// ---------------------------------------------------------------------------
module r5p_reset_button_ctl
  import r5p_rst_pkg::*;
#(
  parameter int unsigned SYNC_FF = SYNC_FF_DEF,
  parameter int unsigned DEB_CNT = DEB_CNT_DEF,
  parameter int unsigned RST_LEN = RST_LEN_DEF,
  parameter logic        BTN_POL = BTN_POL_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
`ifdef R5P_RST_LOCK_EN
  input  logic pll_lock,
`endif
  output logic rst,
  output logic btn_deb,
  output logic btn_press,
  output logic btn_release
);

  localparam int unsigned    HCW      = $clog2(RST_LEN + 1);
  localparam logic [HCW-1:0] HCNT_MAX = HCW'(RST_LEN - 1);

  rst_st_t        state_q, state_d;
  logic [HCW-1:0] hcnt_q,  hcnt_d;
  logic           rst_q;
  logic           lock_s;

  r5p_debounce #(
    .SYNC_FF (SYNC_FF),
    .DEB_CNT (DEB_CNT),
    .BTN_POL (BTN_POL)
  ) u_deb (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_i         (btn_i),
    .btn_deb_o     (btn_deb),
    .btn_press_o   (btn_press),
    .btn_release_o (btn_release)
  );

`ifdef R5P_RST_LOCK_EN
  logic [SYNC_FF-1:0] lock_sync_q;

  // Lock synchronizer. Resets to "locked" so a stable lock gives the same
  // power-on stretch as the plain build; the FSM holds reset anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync_q <= {SYNC_FF{1'b1}};
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_FF-2:0], pll_lock};
    end
  end

  assign lock_s = lock_sync_q[SYNC_FF-1];
`else
  assign lock_s = 1'b1;
`endif

  // Reset FSM next state; loss of lock overrides everything.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    if (!lock_s) begin
      state_d = ST_HOLD;
      hcnt_d  = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (btn_deb) begin
            state_d = ST_PRESSED;
            hcnt_d  = '0;
          end else if (hcnt_q == HCNT_MAX) begin
            state_d = ST_RUN;
            hcnt_d  = '0;
          end else begin
            hcnt_d = hcnt_q + HCW'(1);
          end
        end
        ST_RUN: begin
          hcnt_d = '0;
          if (btn_deb) begin
            state_d = ST_PRESSED;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_PRESSED: begin
          hcnt_d = '0;
          if (!btn_deb) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_PRESSED;
          end
        end
        default: begin
          state_d = ST_HOLD;
          hcnt_d  = '0;
        end
      endcase
    end
  end

  // FSM state, hold counter and the registered SoC reset (from next state,
  // so rst changes on the same edge as the state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HOLD;
      hcnt_q  <= '0;
      rst_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      rst_q   <= rst_of_state(state_d);
    end
  end

  assign rst = rst_q;

endmodule

// File: tb/tb_r5p_reset_button_ctl.sv
// ---------------------------------------------------------------------------
// tb_r5p_reset_button_ctl
// Scoreboard bench: each stimulus step pushes the expected output vector
// {rst, btn_deb, btn_press, btn_release} for the cycles it affects; a
// negedge monitor pops and compares entries as their cycle comes up.
// ---------------------------------------------------------------------------
module tb_r5p_reset_button_ctl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_i = 1'b1;
  logic pll_lock = 1'b1;
  logic rst, btn_deb, btn_press, btn_release;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    string      tag;
    int         c;
    logic [3:0] v;
  } exp_t;

  exp_t sb[$];

  r5p_reset_button_ctl #(
    .SYNC_FF (2),
    .DEB_CNT (4),
    .RST_LEN (8),
    .BTN_POL (1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_i       (btn_i),
`ifdef R5P_RST_LOCK_EN
    .pll_lock    (pll_lock),
`endif
    .rst         (rst),
    .btn_deb     (btn_deb),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  always #5 clk = ~clk;

  // Count rising edges; the monitor at the following negedge sees cycle cyc.
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic exp_span(input string tag, input int c0, input int c1, input logic [3:0] v);
    exp_t e;
    for (int c = c0; c <= c1; c++) begin
      e.tag = tag;
      e.c   = c;
      e.v   = v;
      sb.push_back(e);
    end
  endtask

  // Advance to just after rising edge number c.
  task automatic go_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor: compare every expectation due this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].c <= cyc) begin
      e = sb.pop_front();
      if (e.c < cyc) begin
        check_eq({e.tag, "_late"}, 32'(cyc), 32'(e.c));
      end else begin
        check_eq(e.tag, {28'd0, rst, btn_deb, btn_press, btn_release}, {28'd0, e.v});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;

    // Power-on reset: 3 cycles low, then exactly 8 cycles of rst after release.
    exp_span("por_in_rst", 1, 3, 4'b1000);
    go_to(3);
    rst_n = 1'b1;
    k = cyc;
    exp_span("por_hold", k + 1, k + 7, 4'b1000);
    exp_span("por_run",  k + 8, k + 15, 4'b0000);
    go_to(k + 15);

    // Steady press from RUN: deb/press at +6, rst at +7; hold it for 20 cycles.
    k = cyc;
    btn_i = 1'b0;
    exp_span("press_wait", k + 1, k + 5,  4'b0000);
    exp_span("press_edge", k + 6, k + 6,  4'b0110);
    exp_span("press_rst",  k + 7, k + 20, 4'b1100);
    go_to(k + 20);

    // Release: release pulse at +6, rst stays high until 9 cycles later.
    k = cyc;
    btn_i = 1'b1;
    exp_span("rel_wait", k + 1,  k + 5,  4'b1100);
    exp_span("rel_edge", k + 6,  k + 6,  4'b1001);
    exp_span("rel_hold", k + 7,  k + 14, 4'b1000);
    exp_span("rel_run",  k + 15, k + 18, 4'b0000);
    go_to(k + 18);

    // Bounce 0,1,0,1,0 one cycle each then steady released: nothing moves.
    k = cyc;
    exp_span("bounce", k + 1, k + 16, 4'b0000);
    for (int i = 0; i < 6; i++) begin
      btn_i = (i % 2 == 1);
      go_to(k + i + 1);
    end
    go_to(k + 16);

    // Press again, then assert rst_n while in ST_PRESSED.
    k = cyc;
    btn_i = 1'b0;
    exp_span("p2_wait", k + 1, k + 5, 4'b0000);
    exp_span("p2_edge", k + 6, k + 6, 4'b0110);
    exp_span("p2_rst",  k + 7, k + 9, 4'b1100);
    go_to(k + 10);
    rst_n = 1'b0;
    btn_i = 1'b1;
    #1;
    check_eq("async_rst", {28'd0, rst, btn_deb, btn_press, btn_release}, 32'h0000_0008);
    k = cyc;
    exp_span("rst2_in", k + 1, k + 3, 4'b1000);
    go_to(k + 3);
    rst_n = 1'b1;
    k = cyc;
    exp_span("rst2_hold", k + 1, k + 7,  4'b1000);
    exp_span("rst2_run",  k + 8, k + 12, 4'b0000);
    go_to(k + 12);

`ifdef R5P_RST_LOCK_EN
    // One-cycle lock drop: rst at +3, low 8 cycles after lock_s returns.
    k = cyc;
    pll_lock = 1'b0;
    exp_span("lock_wait", k + 1,  k + 2,  4'b0000);
    exp_span("lock_hold", k + 3,  k + 10, 4'b1000);
    exp_span("lock_run",  k + 11, k + 13, 4'b0000);
    go_to(k + 1);
    pll_lock = 1'b1;
    go_to(k + 13);
`endif

    go_to(cyc + 2);
    check_eq("sb_drain", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
